// File: rtl/brightness_ctrl.sv
// brightness_ctrl: measures mean luma per frame and steps a saturated brightness offset towards a target
// Define BRIGHTNESS_CTRL_IIR_EN to smooth the measured mean with a 3/4 IIR before it drives err and O_mean.
module brightness_ctrl #(
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 22,
    parameter int OFF_MAX = 64
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [95:0] I_tdata,
    input  logic        I_tvalid,
    input  logic        I_tready,
    input  logic        I_tuser,
    input  logic        I_enable,
    input  logic [7:0]  I_target,
    input  logic [3:0]  I_step,
    input  logic [7:0]  I_deadband,
    output logic [8:0]  O_offset,
    output logic        O_offset_valid,
    output logic [7:0]  O_mean,
    output logic        O_drop
);
    localparam int BW = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, UPDATE} state_t;
    state_t r_state, w_next;

    logic [ACC_W-1:0]  r_acc, r_quo;
    logic [CNT_W-1:0]  r_cnt, r_dvs, r_rem;
    logic [BW-1:0]     r_bit;
    logic              w_beat, w_sof, w_ge, w_adjust;
    logic [9:0]        w_luma, w_abs;
    logic [ACC_W:0]    w_acc_sum;
    logic [CNT_W:0]    w_trial, w_diff;
    logic [7:0]        w_mean_raw, w_mean;
    logic signed [9:0] w_err, w_step, w_off_sum;
    logic signed [8:0] w_off_new;

    assign w_beat = I_tvalid & I_tready;
    assign w_sof  = w_beat & I_tuser;

    always_comb begin
        w_luma = '0;
        for (int k = 0; k < 4; k++)
            w_luma = w_luma + ((10'(I_tdata[24*k+16 +: 8]) + {1'b0, I_tdata[24*k+8 +: 8], 1'b0} + 10'(I_tdata[24*k +: 8])) >> 2);
    end

    assign w_acc_sum = {1'b0, r_acc} + {{(ACC_W-9){1'b0}}, w_luma};

    // restoring divider: the borrow of the trial subtraction decides each quotient bit
    assign w_trial    = {r_rem, r_quo[ACC_W-1]};
    assign w_diff     = w_trial - {1'b0, r_dvs};
    assign w_ge       = ~w_diff[CNT_W];
    assign w_mean_raw = |r_quo[ACC_W-1:10] ? 8'hFF : r_quo[9:2];

`ifdef BRIGHTNESS_CTRL_IIR_EN
    logic r_first;
    always_ff @(posedge I_clk) begin
        if (I_rst || r_state == IDLE) r_first <= 1'b1;
        else if (r_state == UPDATE && I_enable) r_first <= 1'b0;
    end
    assign w_mean = r_first ? w_mean_raw : 8'((10'(O_mean) * 10'd3 + 10'(w_mean_raw) + 10'd2) >> 2);
`else
    assign w_mean = w_mean_raw;
`endif

    assign w_err     = $signed({2'b0, I_target}) - $signed({2'b0, w_mean});
    assign w_abs     = w_err[9] ? 10'(-w_err) : w_err;
    assign w_adjust  = w_abs > {2'b0, I_deadband};
    assign w_step    = w_err[9] ? -$signed({6'b0, I_step}) : $signed({6'b0, I_step});
    assign w_off_sum = $signed({O_offset[8], O_offset}) + w_step;
    assign w_off_new = (w_off_sum > OFF_MAX) ? 9'(OFF_MAX) : (w_off_sum < -OFF_MAX) ? 9'(-OFF_MAX) : w_off_sum[8:0];

    always_ff @(posedge I_clk) begin
        if (I_rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!I_enable) w_next = IDLE;
        else case (r_state)
            IDLE:    if (w_sof) w_next = ACCUM;
            ACCUM:   if (w_sof) w_next = DIV;
            DIV:     if (r_bit == BW'(ACC_W - 1)) w_next = UPDATE;
            UPDATE:  w_next = ACCUM;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_acc          <= '0;
            r_cnt          <= '0;
            r_quo          <= '0;
            r_dvs          <= '0;
            r_rem          <= '0;
            r_bit          <= '0;
            O_offset       <= '0;
            O_offset_valid <= 1'b0;
            O_mean         <= '0;
            O_drop         <= 1'b0;
        end else begin
            O_offset_valid <= 1'b0;
            O_drop         <= 1'b0;
            if (!I_enable) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                if (w_sof) begin
                    r_acc <= ACC_W'(w_luma);
                    r_cnt <= CNT_W'(1);
                end else if (w_beat && r_state != IDLE) begin
                    r_acc <= w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
                    r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
                end
                if (r_state == ACCUM && w_sof) begin
                    r_quo <= r_acc;
                    r_dvs <= r_cnt;
                    r_rem <= '0;
                    r_bit <= '0;
                end
                if (r_state == DIV) begin
                    r_rem <= w_ge ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
                    r_quo <= {r_quo[ACC_W-2:0], w_ge};
                    r_bit <= r_bit + 1'b1;
                end
                if ((r_state == DIV || r_state == UPDATE) && w_sof) O_drop <= 1'b1;
                if (r_state == UPDATE) begin
                    O_mean         <= w_mean;
                    O_offset       <= w_adjust ? w_off_new : O_offset;
                    O_offset_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_brightness_ctrl.sv
// tb_brightness_ctrl: random and directed frames against a frame-level reference model of the controller.
// Define BRIGHTNESS_CTRL_IIR_EN for both bench and design to exercise the IIR build.
module tb_brightness_ctrl;
    localparam int ACC_W   = 32;
    localparam int CNT_W   = 22;
    localparam int OFF_MAX = 64;
    localparam int LAT     = ACC_W + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] tdata = '0;
    logic        tvalid = 1'b0, tready = 1'b0, tuser = 1'b0, enable = 1'b0;
    logic [7:0]  target = '0, deadband = '0;
    logic [3:0]  step = '0;
    logic [8:0]  offset;
    logic        offset_valid, drop;
    logic [7:0]  mean;

    always #5 clk = ~clk;

    brightness_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W), .OFF_MAX(OFF_MAX)) dut (
        .I_clk(clk), .I_rst(rst), .I_tdata(tdata), .I_tvalid(tvalid), .I_tready(tready),
        .I_tuser(tuser), .I_enable(enable), .I_target(target), .I_step(step), .I_deadband(deadband),
        .O_offset(offset), .O_offset_valid(offset_valid), .O_mean(mean), .O_drop(drop)
    );

    typedef struct {int due; int off; int mean;} upd_t;
    upd_t   upd_q[$];
    int     drop_q[$];
    int     n_vec = 0, n_err = 0, cyc = 0, n_drop = 0;
    int     m_off = 0, m_mean = 0, s_off = 0, s_prev = 0, busy_until = -1000, fr_cnt = 0;
    longint fr_sum = 0;
    bit     s_first = 1'b1, fr_open = 1'b0, mon_en = 1'b0, ev, dr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, $signed(got), $signed(exp), cyc);
        end
    endtask

    // a finished frame becomes one expected update: mean, optional IIR, deadband, step, clamp
    function automatic void close_frame();
        int mn = int'(fr_sum / fr_cnt) / 4;
        int err;
        if (mn > 255) mn = 255;
`ifdef BRIGHTNESS_CTRL_IIR_EN
        if (!s_first) mn = (3 * s_prev + mn + 2) / 4;
`endif
        s_first = 1'b0;
        s_prev  = mn;
        err = int'(target) - mn;
        if (err > int'(deadband) || -err > int'(deadband)) begin
            s_off += (err > 0) ? int'(step) : -int'(step);
            if (s_off > OFF_MAX) s_off = OFF_MAX;
            if (s_off < -OFF_MAX) s_off = -OFF_MAX;
        end
        upd_q.push_back('{cyc + LAT, s_off, mn});
        busy_until = cyc + ACC_W + 1;
    endfunction

    function automatic void accept(input logic [95:0] d, input bit u);
        int l = 0;
        for (int k = 0; k < 4; k++)
            l += (int'(d[24*k+16 +: 8]) + 2 * int'(d[24*k+8 +: 8]) + int'(d[24*k +: 8])) / 4;
        if (u) begin
            if (fr_open) begin
                if (cyc <= busy_until) drop_q.push_back(cyc + 1);
                else close_frame();
            end
            fr_open = 1'b1;
            fr_sum  = l;
            fr_cnt  = 1;
        end else if (fr_open) begin
            fr_sum += l;
            fr_cnt++;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            ev = upd_q.size() > 0 && upd_q[0].due == cyc;
            dr = drop_q.size() > 0 && drop_q[0] == cyc;
            if (ev) begin
                m_off  = upd_q[0].off;
                m_mean = upd_q[0].mean;
                void'(upd_q.pop_front());
            end
            if (dr) void'(drop_q.pop_front());
            if (drop) n_drop++;
            check("offset_valid", 32'(offset_valid), 32'(ev));
            check("drop", 32'(drop), 32'(dr));
            check("offset", 32'($signed(offset)), m_off);
            check("mean", 32'(mean), m_mean);
        end
    end

    task automatic beat(input logic [95:0] d, input bit v, input bit r, input bit u);
        tdata  = d;
        tvalid = v;
        tready = r;
        tuser  = u;
        if (v && r && enable && !rst) accept(d, u);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat({$urandom, $urandom, $urandom}, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    task automatic frame(input logic [23:0] px, input int nb, input int nst, input int gap, input bit rnd);
        int st = nst;
        for (int i = 0; i < nb; i++) begin
            while (i > 0 && st > 0 && (i == nb - 1 || $urandom_range(1) == 1)) begin
                beat({4{24'hFFFFFF}}, 1'b1, 1'b0, 1'b0);
                st--;
            end
            if (rnd && $urandom_range(7) == 0) beat({$urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'($urandom_range(1)));
            if (rnd && i == 0 && $urandom_range(3) == 0) beat({4{px}}, 1'b1, 1'b0, 1'b1);
            beat((rnd && $urandom_range(1) == 1) ? {$urandom, $urandom, $urandom} : {4{px}}, 1'b1, 1'b1, i == 0);
        end
        idle(gap);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        mon_en = 1'b0;
        upd_q.delete();
        drop_q.delete();
        m_off = 0; m_mean = 0; s_off = 0; s_prev = 0; s_first = 1'b1;
        fr_open = 1'b0; busy_until = -1000;
        repeat (3) beat('0, 1'b0, 1'b0, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    // an update not yet registered when enable drops is abandoned
    task automatic en_low(input int n);
        enable = 1'b0;
        while (upd_q.size() > 0 && upd_q[$].due > cyc) void'(upd_q.pop_back());
        s_off   = upd_q.size() > 0 ? upd_q[$].off : m_off;
        s_prev  = upd_q.size() > 0 ? upd_q[$].mean : m_mean;
        s_first = 1'b1;
        fr_open = 1'b0;
        busy_until = -1000;
        idle(n);
        enable = 1'b1;
    endtask

    initial begin
        int n0;
        do_reset();
        idle(10);
        check("reset_offset", 32'($signed(offset)), 0);
        check("reset_mean", 32'(mean), 0);

        enable = 1'b1; target = 8'd128; step = 4'd4; deadband = 8'd8;
        repeat (3) frame(24'h404040, 16, 0, LAT, 1'b0);
        check("dark_offset", 32'($signed(offset)), 8);
        check("dark_mean", 32'(mean), 64);

        frame(24'h404040, 16, 0, 0, 1'b0);
        en_low(5);
        idle(LAT + 5);
        check("enable_abort_offset", 32'($signed(offset)), 8);

        frame(24'h404040, 16, 0, 0, 1'b0);
        frame(24'h404040, 16, 0, 0, 1'b0);
        do_reset();
        idle(LAT + 5);
        check("reset_abort_offset", 32'($signed(offset)), 0);

        target = 8'd128; step = 4'd15; deadband = 8'd8;
        repeat (7) frame(24'hC8C8C8, 16, 0, LAT, 1'b0);
        check("bright_sat_offset", 32'($signed(offset)), -64);
        check("bright_mean", 32'(mean), 200);

        do_reset();
        step = 4'd4;
        repeat (3) frame(24'h828282, 16, 0, LAT, 1'b0);
        check("deadband_offset", 32'($signed(offset)), 0);
        check("deadband_mean", 32'(mean), 130);

        do_reset();
        frame(24'h404040, 16, 5, LAT, 1'b0);
        frame(24'h404040, 1, 0, LAT, 1'b0);
        check("stall_mean", 32'(mean), 64);
        check("stall_offset", 32'($signed(offset)), 4);

        do_reset();
        n0 = n_drop;
        frame(24'h404040, 16, 0, 0, 1'b0);
        frame(24'h707070, 5, 0, 0, 1'b0);
        frame(24'h707070, 16, 0, LAT, 1'b0);
        frame(24'h707070, 1, 0, LAT, 1'b0);
        check("drop_count", n_drop - n0, 1);
`ifdef BRIGHTNESS_CTRL_IIR_EN
        check("drop_then_mean", 32'(mean), 76);
`else
        check("drop_then_mean", 32'(mean), 112);
`endif

        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(3) == 0) do_reset();
            target   = 8'($urandom_range(255));
            step     = 4'($urandom_range(15));
            deadband = 8'($urandom_range(40));
            enable   = 1'b1;
            for (int f = 0; f < int'($urandom_range(6, 3)); f++) begin
                frame(24'($urandom), $urandom_range(40, 1), $urandom_range(4), $urandom_range(20), 1'b1);
                if ($urandom_range(7) == 0) en_low($urandom_range(4, 1));
            end
            frame(24'($urandom), 1, 0, LAT + 2, 1'b0);
        end
        check("pending_updates", upd_q.size(), 0);
        check("pending_drops", drop_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
